ring_req_port: RTL and testbench
================================

# ring_req_port

Requester-side packet port for a ring router output channel. It buffers flits from a local source and raises `req` to the channel's 3-input arbiter. It streams the packet onto the link while `gnt` is held, then drops `req` and waits for `gnt` to fall before competing again. One instance sits on each arbiter input (`req00/01/02` ↔ `gnt00/01/02`).

## Interface
Parameters:
- `DATA_W`, 32: flit payload width.
- `DEPTH`, 4: flit FIFO depth in entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  source flit valid.
- `in_data`  in  DATA_W  source flit payload.
- `in_tail`  in  1  flit is last of packet.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `req`  out  1  registered request to arbiter.
- `gnt`  in  1  registered grant from arbiter.
- `out_valid`  out  1  link flit valid.
- `out_data`  out  DATA_W  link flit payload.
- `out_tail`  out  1  link flit is tail.
- `out_ready`  in  1  link accepts flit.

## Operation
- FIFO: DEPTH × (DATA_W+1), storing {tail, data}.
  - Push when `in_valid && in_ready`.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle are both allowed, including when full (`in_ready`=0 blocks the push) and when empty (nothing to pop).
- `pkt_cnt`: number of tail flits currently stored, 0..DEPTH.
  - +1 on a tail push, −1 on a tail pop; both in one cycle leaves it unchanged.
- FSM states: IDLE, REQ, SEND, RELEASE.
  - IDLE: `req`=0. Go to REQ when `pkt_cnt`≠0 or FIFO full. The full case is a packet longer than DEPTH, which is sent cut-through.
  - REQ: `req`=1. Go to SEND on the edge where `gnt`=1.
  - SEND: `req`=1, `out_valid` = !empty. If the FIFO empties mid-packet, `out_valid`=0 and the block stays in SEND, holding the grant. Go to RELEASE on the edge of the tail pop.
  - RELEASE: `req`=0, no flits presented. Go to IDLE on the edge where `gnt`=0.
- `gnt` falling while in SEND is an arbiter protocol error. Go to REQ and re-request; do not present flits in that cycle.
- `gnt` is ignored in IDLE; the arbiter's 2-cycle grant tail may still be high then.
- `out_data`/`out_tail` come from the FIFO head combinationally. They are don't-care when `out_valid`=0.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE, FIFO empty, `pkt_cnt`=0.
  - After that edge: `req`=0, `out_valid`=0, `in_ready`=1.
  - Applies from any state, including mid-SEND; buffered flits are discarded.
- Tail push accepted at edge E:
  - `pkt_cnt`≠0 after E.
  - State=REQ and `req`=1 after E+1.
- The arbiter registers both state and grant. From an idle arbiter, `gnt` rises 2 edges after `req` rises.
  - The port enters SEND on the edge sampling `gnt`=1.
  - The first flit is valid in the following cycle.
- One flit per cycle while `out_ready`=1. Tail pop at edge T: state=RELEASE and `req`=0 after T.
- `gnt` falls 2 edges after `req` falls.
  - The port must not reassert `req` until it samples `gnt`=0.
  - This guarantees a lower-priority port one arbitration slot.
- Minimum `req` low time: 2 cycles.

## Structure
- Shared package `ring_pkg`:
  - FSM state encoding, one-hot `localparam`s.
  - Flit field offsets (TAIL_BIT = DATA_W).
  - Default DATA_W.
- One sub-module: `ring_flit_fifo`, a synchronous FIFO with full/empty outputs, wrap-around pointers, and an occupancy count. The FSM and `pkt_cnt` live in the top module.

## Test plan
- Single packet: push 3 flits A,B,C (C tail) with the arbiter model idle and `out_ready`=1 → `req` rises 2 cycles after C is accepted; A,B,C appear on consecutive cycles starting 1 cycle after `gnt`; `out_tail`=1 only on C; `req`=0 the cycle after C.
- Back-to-back: two 2-flit packets queued → after the first tail, `req` stays 0 until `gnt`=0 is sampled (≥2 cycles); the second packet is then sent with no flit lost or duplicated.
- Backpressure: toggle `out_ready` 1,0,0,1 during SEND → each flit is held stable while `out_ready`=0; order is preserved; `req` stays 1.
- Long packet: DEPTH=4, 7-flit packet with the source throttled → request is made on full with no tail; `out_valid` drops when the FIFO empties mid-packet; grant is held; all 7 flits are delivered in order.
- Full boundary: fill the FIFO, then apply push and pop in the same cycle → `in_ready`=0 blocks the push; the pop succeeds; `in_ready`=1 the next cycle.
- Reset mid-SEND: assert `rst`=0 for one edge after the 2nd flit → `req`=0 and `out_valid`=0 next cycle; FIFO empty; state=IDLE; a new packet is then handled normally.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared definitions for the ring router requester port: FSM states,
// flit field layout and the default payload width.
package ring_pkg;

    localparam int unsigned RING_DATA_W = 32;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_REQ     = 4'b0010,
        ST_SEND    = 4'b0100,
        ST_RELEASE = 4'b1000
    } port_state_t;

    // A stored flit is {tail, data}; the tail flag sits just above the payload.
    function automatic int unsigned tail_bit(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/ring_flit_fifo.sv
// Synchronous flit FIFO with wrap-around pointers, occupancy count and
// combinational head read.
module ring_flit_fifo
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = RING_DATA_W + 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ring_req_port.sv
// Requester-side ring port: buffers source flits, requests the output
// channel arbiter and streams whole packets while the grant is held.
module ring_req_port
    import ring_pkg::*;
#(
    parameter int unsigned DATA_W = RING_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_tail,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tail,
    input  logic              out_ready
);

    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam int unsigned TAIL_BIT = tail_bit(DATA_W);

    port_state_t     state;
    port_state_t     state_nxt;
    logic [CW-1:0]   pkt_cnt;
    logic [CW-1:0]   fifo_count;
    logic [DATA_W:0] head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            tail_push;
    logic            tail_pop;

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head[DATA_W-1:0];
    assign out_tail  = head[TAIL_BIT];
    assign tail_push = push && in_tail;
    assign tail_pop  = pop && out_tail;

    ring_flit_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_tail, in_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt <= '0;
        end else if (tail_push && !tail_pop) begin
            pkt_cnt <= pkt_cnt + CW'(1);
        end else if (tail_pop && !tail_push) begin
            pkt_cnt <= pkt_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A full FIFO with no tail is a long packet sent cut-through.
                if (pkt_cnt != '0 || fifo_count == CW'(DEPTH)) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                if (gnt) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                req = 1'b1;
                if (!gnt) begin
                    state_nxt = ST_REQ;
                end else begin
                    out_valid = !empty;
                    // Tail pop decoded from the head here to keep pop out of the loop.
                    if (!empty && out_ready && out_tail) state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!gnt) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ring_req_port.sv
// Randomized and directed bench for ring_req_port against a queue-based
// reference model and a two-stage registered arbiter model.
module tb_ring_req_port;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_tail;
    logic          in_ready;
    logic          req;
    logic          gnt = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_tail;
    logic          out_ready;

    logic req_d = 1'b0;
    logic gnt_drop = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [DW:0] q[$];
    int   cyc = 0;
    int   n_pops = 0;
    int   req_rises = 0;
    bit   req_prev = 0, waiting = 0, tailpop_prev = 0, stall_prev = 0, rst_prev_low = 0;
    int   fall_cyc = -100, clear_cyc = -100;
    int   o_cyc;
    logic o_req, o_gnt, o_valid, o_in_ready, o_push, o_pop, o_tailpop;

    always #5 clk = ~clk;

    ring_req_port #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tail  (out_tail),
        .out_ready (out_ready)
    );

    // Arbiter registers state then grant: gnt follows req by two edges.
    always @(posedge clk) begin
        req_d <= req;
        gnt   <= req_d && !gnt_drop;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: check current outputs against the model, then advance it.
    task automatic step();
        logic push, pop;
        #1;
        o_cyc = cyc; o_req = req; o_gnt = gnt; o_valid = out_valid; o_in_ready = in_ready;
        if (rst_prev_low) begin
            check_val("rst_req", req, 1'b0);
            check_val("rst_valid", out_valid, 1'b0);
            check_val("rst_in_ready", in_ready, 1'b1);
        end
        check_val("in_ready", in_ready, q.size() < DEPTH);
        check_val("valid_needs_grant", out_valid && !(req && gnt), 1'b0);
        if (tailpop_prev) check_val("req_after_tail", req, 1'b0);
        if (stall_prev && gnt === 1'b1) check_val("hold_valid", out_valid, 1'b1);
        if (out_valid) begin
            if (q.size() == 0) check_val("spurious_flit", out_valid, 1'b0);
            else               check_val("flit", {out_tail, out_data}, q[0]);
        end
        if (req && !req_prev) begin
            req_rises++;
            check_val("req_rearm", !waiting && (cyc - clear_cyc >= 2) && (cyc - fall_cyc >= 2), 1'b1);
        end
        if (!req && req_prev) begin waiting = 1; fall_cyc = cyc; end
        if (!req && waiting && gnt === 1'b0) begin waiting = 0; clear_cyc = cyc; end
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        o_push = push; o_pop = pop; o_tailpop = pop && out_tail;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            q.delete();
            waiting = 0; req_prev = 0; tailpop_prev = 0; stall_prev = 0; rst_prev_low = 1;
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push) q.push_back({in_tail, in_data});
            if (pop) n_pops++;
            req_prev = o_req; tailpop_prev = o_tailpop;
            stall_prev = o_valid && !out_ready;
            rst_prev_low = 0;
        end
        @(negedge clk);
    endtask

    task automatic push_flit(input logic tail);
        bit ok = 0;
        in_valid = 1'b1; in_tail = tail; in_data = $urandom();
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = o_push;
        end
        in_valid = 1'b0; in_tail = 1'b0;
        check_val("push_accepted", ok, 1'b1);
    endtask

    task automatic wait_quiet(input int budget);
        bit ok = 0;
        in_valid = 1'b0; gnt_drop = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            ok = (q.size() == 0) && !o_req && (o_gnt === 1'b0);
        end
        check_val("quiet", ok, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_tail, t_req, t_gnt, t_valid, t_end, k, n, thr, p0, r0;
        bit done, gap_seen;
        logic [3:0] pat;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_tail = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; rst_prev_low = 1;
        wait_quiet(10);

        // Single packet: latency and back-to-back flits.
        push_flit(1'b0); push_flit(1'b0); push_flit(1'b1);
        t_tail = o_cyc + 1;
        t_req = -1; t_gnt = -1; t_valid = -1; t_end = -1;
        for (int i = 0; i < 40 && t_end < 0; i++) begin
            step();
            if (o_req && t_req < 0) t_req = o_cyc;
            if (o_gnt === 1'b1 && t_gnt < 0) t_gnt = o_cyc;
            if (o_valid && t_valid < 0) t_valid = o_cyc;
            if (o_tailpop) t_end = o_cyc + 1;
        end
        check_val("req_latency", t_req - t_tail, 1);
        check_val("first_flit_latency", t_valid - t_gnt, 1);
        check_val("burst_length", t_end - t_valid, 3);
        wait_quiet(20);

        // Back-to-back packets queued before sending.
        r0 = req_rises; p0 = n_pops;
        out_ready = 1'b0;
        push_flit(1'b0); push_flit(1'b1); push_flit(1'b0); push_flit(1'b1);
        out_ready = 1'b1;
        wait_quiet(100);
        check_val("b2b_requests", req_rises - r0, 2);
        check_val("b2b_pops", n_pops - p0, 4);

        // Backpressure 1,0,0,1 during SEND.
        pat = 4'b1001; k = 0; done = 0;
        out_ready = 1'b0;
        push_flit(1'b0); push_flit(1'b0); push_flit(1'b0); push_flit(1'b1);
        for (int i = 0; i < 60 && !done; i++) begin
            out_ready = pat[k % 4];
            step();
            if (o_valid) begin
                if (!out_ready) check_val("bp_req_held", o_req, 1'b1);
                k++;
            end
            done = o_tailpop;
        end
        check_val("bp_done", done, 1'b1);
        wait_quiet(20);

        // Long 7-flit packet, throttled source, cut-through on full.
        p0 = n_pops; n = 0; thr = 0; t_req = -1; t_valid = -1; done = 0; gap_seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            in_valid = (n < 7) && (thr == 0); in_tail = (n == 6); in_data = $urandom();
            step();
            if (o_req && t_req < 0) begin
                t_req = o_cyc;
                check_val("long_req_before_tail", n < 7, 1'b1);
            end
            if (o_valid && t_valid < 0) t_valid = o_cyc;
            if (t_valid >= 0 && o_req && o_gnt === 1'b1 && !o_valid) gap_seen = 1;
            if (o_push) begin n++; thr = 2; end
            else if (thr > 0) thr--;
            done = o_tailpop;
        end
        in_valid = 1'b0; in_tail = 1'b0;
        check_val("long_done", done, 1'b1);
        check_val("long_gap_seen", gap_seen, 1'b1);
        check_val("long_pops", n_pops - p0, 7);
        wait_quiet(30);

        // Full boundary: simultaneous push and pop while full.
        out_ready = 1'b0;
        push_flit(1'b0); push_flit(1'b0); push_flit(1'b0); push_flit(1'b0);
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin step(); done = o_valid; end
        check_val("full_granted", done, 1'b1);
        in_valid = 1'b1; in_tail = 1'b1; in_data = $urandom(); out_ready = 1'b1;
        step();
        check_val("full_push_blocked", o_push, 1'b0);
        check_val("full_pop", o_pop, 1'b1);
        step();
        check_val("ready_after_pop", o_in_ready, 1'b1);
        in_valid = 1'b0; in_tail = 1'b0;
        wait_quiet(40);

        // Reset after the second flit of a packet.
        out_ready = 1'b0;
        push_flit(1'b0); push_flit(1'b0); push_flit(1'b0); push_flit(1'b1);
        p0 = n_pops; out_ready = 1'b1; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin step(); done = (n_pops - p0 == 2); end
        check_val("rst_two_flits", done, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin step(); done = (o_gnt === 1'b0); end
        check_val("post_rst_gnt_low", done, 1'b1);
        p0 = n_pops;
        push_flit(1'b0); push_flit(1'b1);
        wait_quiet(40);
        check_val("post_rst_pkt", n_pops - p0, 2);

        // Random traffic with occasional grant glitches.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom() % 2) == 0;
            in_tail   = ($urandom() % 4) == 0;
            in_data   = $urandom();
            out_ready = ($urandom() % 4) != 0;
            gnt_drop  = ($urandom() % 40) == 0;
            step();
        end
        gnt_drop = 1'b0; out_ready = 1'b1;
        push_flit(1'b1);
        wait_quiet(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
